mux8_scan_deser: RTL and testbench

//  Receive-side counterpart of the 8:1 select mux: drives the 3-bit lane select

---
 rtl/mux8_scan_deser.sv | 140 ++++++++++++++
 tb/tb_mux8_scan_deser.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_scan_deser.sv
// Deserialiser for an external 8:1 select mux: scans sel_out over all lanes, samples ser_in
// into a shadow word, then presents the completed word on a valid/ready port.
// Optional feature macro: MUX8_SCAN_PARITY_EN (adds a parity beat per word and drives par_err).
module mux8_scan_deser #(
  parameter int LANES     = 8,
  parameter int SELW      = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [SELW-1:0]  sel_out,
  output logic [LANES-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             par_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
`ifdef MUX8_SCAN_PARITY_EN
    S_PAR,
`endif
    S_HOLD
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             last_beat;
  logic [SELW-1:0]  bit_idx;
  logic [LANES-1:0] shadow;
  logic [LANES-1:0] shadow_upd;

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    ser_ready  = 1'b0;
    state_nxt  = state;
    last_beat  = (sel_out == SELW'(LANES - 1));
    bit_idx    = MSB_FIRST ? (SELW'(LANES - 1) - sel_out) : sel_out;
    shadow_upd = shadow;
    shadow_upd[bit_idx] = ser_in;

    case (state)
      S_IDLE: begin
        if (!en_n) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        ser_ready = 1'b1;
        if (en_n) begin
          state_nxt = S_IDLE;
        end else if (ser_valid && last_beat) begin
`ifdef MUX8_SCAN_PARITY_EN
          state_nxt = S_PAR;
`else
          state_nxt = S_HOLD;
`endif
        end
      end
`ifdef MUX8_SCAN_PARITY_EN
      S_PAR: begin
        ser_ready = 1'b1;
        if (en_n)           state_nxt = S_IDLE;
        else if (ser_valid) state_nxt = S_HOLD;
      end
`endif
      S_HOLD: begin
        if (par_ready) state_nxt = en_n ? S_IDLE : S_SHIFT;
      end
      default: state_nxt = S_IDLE;
    endcase

    accept = ser_valid & ser_ready & ~en_n;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

`ifdef MUX8_SCAN_PARITY_EN
  logic par_err_q;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_out   <= '0;
      shadow    <= '0;
      par_out   <= '0;
      par_valid <= 1'b0;
`ifdef MUX8_SCAN_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_SHIFT: begin
          if (en_n) begin
            // Abort: the partial word is dropped and the scan restarts at lane 0.
            sel_out <= '0;
            shadow  <= '0;
          end else if (accept) begin
            shadow  <= shadow_upd;
            sel_out <= last_beat ? '0 : sel_out + SELW'(1);
`ifndef MUX8_SCAN_PARITY_EN
            if (last_beat) begin
              par_out   <= shadow_upd;
              par_valid <= 1'b1;
            end
`endif
          end
        end
`ifdef MUX8_SCAN_PARITY_EN
        S_PAR: begin
          if (en_n) begin
            sel_out <= '0;
            shadow  <= '0;
          end else if (accept) begin
            // Even parity over word plus parity bit; word, flag and valid publish together.
            par_out   <= shadow;
            par_err_q <= (^shadow) ^ ser_in;
            par_valid <= 1'b1;
          end
        end
`endif
        S_HOLD: begin
          if (par_ready) par_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_scan_deser.sv
// Self-checking bench for mux8_scan_deser: LSB-first and MSB-first instances share stimulus
// and are checked against a word-level reference model (directed cases plus random words).
module tb_mux8_scan_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_n;
  logic       ser_in;
  logic       ser_valid;
  logic       par_ready;

  logic       l_ser_ready, m_ser_ready;
  logic [2:0] l_sel, m_sel;
  logic [7:0] l_par, m_par;
  logic       l_pv, m_pv;
  logic       l_err, m_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_l;
  logic [7:0] exp_m;
  logic       exp_err;

  always #5 clk = ~clk;

  mux8_scan_deser #(.LANES(8), .SELW(3), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .en_n(en_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(l_ser_ready), .sel_out(l_sel), .par_out(l_par), .par_valid(l_pv),
    .par_ready(par_ready), .par_err(l_err)
  );

  mux8_scan_deser #(.LANES(8), .SELW(3), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .en_n(en_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(m_ser_ready), .sel_out(m_sel), .par_out(m_par), .par_valid(m_pv),
    .par_ready(par_ready), .par_err(m_err)
  );

  // Reference: sample k carries weight 2**k (LSB-first) or 2**(7-k) (MSB-first).
  function automatic logic [7:0] place(input logic [7:0] samples, input bit msb);
    int acc = 0;
    for (int k = 0; k < 8; k++)
      if (samples[k]) acc += msb ? (1 << (7 - k)) : (1 << k);
    return acc[7:0];
  endfunction

  function automatic logic parity_bad(input logic [7:0] samples, input logic p);
    return (($countones(samples) + int'(p)) % 2) != 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input logic rdy, input logic [2:0] sel);
    check("ser_ready_lsb", l_ser_ready, rdy);
    check("ser_ready_msb", m_ser_ready, rdy);
    check("sel_out_lsb", l_sel, sel);
    check("sel_out_msb", m_sel, sel);
  endtask

  task automatic chk_par(input logic vld);
    check("par_valid_lsb", l_pv, vld);
    check("par_valid_msb", m_pv, vld);
    check("par_out_lsb", l_par, exp_l);
    check("par_out_msb", m_par, exp_m);
    check("par_err_lsb", l_err, exp_err);
    check("par_err_msb", m_err, exp_err);
  endtask

  // One accepted sample, optionally preceded by idle (ser_valid=0) cycles.
  task automatic beat(input logic b, input int gaps, input logic [2:0] sel);
    for (int g = 0; g < gaps; g++) begin
      ser_valid = 1'b0;
      ser_in    = 1'($urandom);
      chk_ready(1'b1, sel);
      chk_par(1'b0);
      step();
    end
    ser_valid = 1'b1;
    ser_in    = b;
    chk_ready(1'b1, sel);
    chk_par(1'b0);
    step();
  endtask

  function automatic int pick_gap(input int gap);
    return (gap >= 0) ? gap : int'($urandom_range(0, 2));
  endfunction

  // Full word; gap < 0 selects random idle cycles before each beat.
  task automatic send_word(input logic [7:0] samples, input logic p, input int gap);
    for (int k = 0; k < 8; k++)
      beat(samples[k], pick_gap(gap), 3'(k));
`ifdef MUX8_SCAN_PARITY_EN
    beat(p, pick_gap(gap), 3'd0);
    exp_err = parity_bad(samples, p);
`else
    exp_err = 1'b0;
    if (p) ser_in = p;
`endif
    exp_l = place(samples, 1'b0);
    exp_m = place(samples, 1'b1);
    // Keep offering samples in HOLD: none may be taken.
    ser_valid = 1'b1;
    ser_in    = 1'($urandom);
    chk_par(1'b1);
    chk_ready(1'b0, 3'd0);
  endtask

  task automatic drain(input int stall, input logic en_hold);
    en_n = en_hold;
    if (stall > 0) par_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      chk_par(1'b1);
      chk_ready(1'b0, 3'd0);
    end
    par_ready = 1'b1;
    step();
    chk_par(1'b0);
    chk_ready(!en_hold, 3'd0);
    ser_valid = 1'b0;
  endtask

  task automatic reenable();
    step();
    chk_ready(1'b0, 3'd0);
    en_n = 1'b0;
    step();
    chk_ready(1'b1, 3'd0);
  endtask

  initial begin
    rst = 1'b1; en_n = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; par_ready = 1'b1;
    exp_l = 8'h00; exp_m = 8'h00; exp_err = 1'b0;
    #3;
    chk_ready(1'b0, 3'd0);
    chk_par(1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk_ready(1'b0, 3'd0);
    en_n = 1'b0;
    step();
    chk_ready(1'b1, 3'd0);

    // Basic word 1,0,1,1,0,0,1,0 -> 8'h4D, valid for exactly one cycle.
    send_word(8'h4D, 1'b0, 0);
    check("t2_word_lsb", l_par, 8'h4D);
    drain(0, 1'b0);

    // Backpressure: word held for 5 cycles, sampling resumes after par_ready.
    send_word(8'($urandom), 1'($urandom), 0);
    drain(5, 1'b0);

    // Gaps and ordering: single leading one.
    send_word(8'h01, 1'b1, 1);
    check("t5_word_msb", m_par, 8'h80);
    check("t5_word_lsb", l_par, 8'h01);
    drain(0, 1'b0);

    // Abort after 4 beats; partial word never surfaces.
    for (int k = 0; k < 4; k++) beat(1'b1, 0, 3'(k));
    en_n = 1'b0;
    ser_valid = 1'b1;
    en_n = 1'b1;
    chk_ready(1'b1, 3'd4);
    step();
    for (int i = 0; i < 3; i++) begin
      chk_ready(1'b0, 3'd0);
      chk_par(1'b0);
      step();
    end
    en_n = 1'b0;
    step();
    chk_ready(1'b1, 3'd0);
    send_word(8'hFF, 1'b0, 0);
    check("t4_word_lsb", l_par, 8'hFF);
    drain(1, 1'b0);

    // en_n raised while a word is pending: word kept until par_ready, then idle.
    send_word(8'($urandom), 1'($urandom), -1);
    drain(2, 1'b1);
    reenable();

`ifdef MUX8_SCAN_PARITY_EN
    send_word(8'h4D, 1'b0, 0);
    check("t6_err_p0", l_err, parity_bad(8'h4D, 1'b0));
    drain(0, 1'b0);
    send_word(8'h4D, 1'b1, 0);
    check("t6_err_p1", l_err, parity_bad(8'h4D, 1'b1));
    drain(0, 1'b0);
`endif

    // Random words with random gaps, stalls and occasional disable during hold.
    for (int w = 0; w < 24; w++) begin
      logic hold_off;
      hold_off = ($urandom_range(0, 3) == 0);
      send_word(8'($urandom), 1'($urandom), -1);
      drain(int'($urandom_range(0, 3)), hold_off);
      if (hold_off) reenable();
    end

    // Reset mid-word with sel_out=5 and a nonzero word on par_out.
    send_word(8'hA5, 1'b0, 0);
    drain(0, 1'b0);
    for (int k = 0; k < 5; k++) beat(1'($urandom), 0, 3'(k));
    chk_ready(1'b1, 3'd5);
    #2;
    rst = 1'b1;
    #1;
    exp_l = 8'h00; exp_m = 8'h00; exp_err = 1'b0;
    chk_ready(1'b0, 3'd0);
    chk_par(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk_ready(1'b1, 3'd0);
    send_word(8'h3C, 1'b1, -1);
    drain(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
